// File: rtl/func_call_accum_if.sv
// Call/result handshake bundle for func_call_accum: a call request channel and a result channel.
// Both channels use valid/ready: a beat transfers on a rising edge where valid && ready are both 1.
interface func_call_accum_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_void;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_void, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_void, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/func_call_accum.sv
// Function-call consumer: returns arg+1 through a small FIFO and accumulates arg+1 as a side effect.
// Void calls apply the side effect only and produce no result beat.
module func_call_accum #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] ACC_INIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  func_call_accum_if.slave     bus,
  output logic [WIDTH-1:0]     acc,
  output logic [15:0]          call_count,
  output logic [15:0]          discard_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             full;
  logic             accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] sum;

  assign full   = (count == DEPTH_C);
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && !bus.in_void;
  assign pop    = bus.out_valid && bus.out_ready;
  assign sum    = bus.in_data + {{(WIDTH-1){1'b0}}, 1'b1};

  // in_ready depends only on registered occupancy, so a pop while full frees the slot next cycle.
  assign bus.in_ready  = !full;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sum;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= ACC_INIT;
      call_count    <= '0;
      discard_count <= '0;
    end else if (accept) begin
      acc <= acc + sum;
      if (call_count != 16'hFFFF) begin
        call_count <= call_count + 16'd1;
      end
      if (bus.in_void && discard_count != 16'hFFFF) begin
        discard_count <= discard_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_func_call_accum.sv
// Directed bench for func_call_accum: value/void calls, backpressure ordering, wrap and mid-run reset.
module tb_func_call_accum;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] acc;
  logic [15:0]      call_count;
  logic [15:0]      discard_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];

  func_call_accum_if #(.WIDTH(WIDTH)) bus ();

  func_call_accum #(
    .WIDTH   (WIDTH),
    .DEPTH   (2),
    .ACC_INIT(32'd1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .acc          (acc),
    .call_count   (call_count),
    .discard_count(discard_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_void   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver: present one call for exactly one edge (caller ensures in_ready is 1).
  task automatic call(input logic [WIDTH-1:0] data, input logic is_void);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_void  = is_void;
    tick();
    bus.in_valid = 1'b0;
    bus.in_void  = 1'b0;
  endtask

  initial begin
    int cyc;
    int pop_cyc;
    int acc_cyc;
    logic accept_now;

    do_reset();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_acc", acc, 32'd1);
    check("rst_call_count", 32'(call_count), 32'd0);
    check("rst_discard_count", 32'(discard_count), 32'd0);

    // Value call then two void calls
    call(32'd10, 1'b0);
    check("val_out_valid", 32'(bus.out_valid), 32'd1);
    check("val_out_data", bus.out_data, 32'd11);
    check("val_acc", acc, 32'd12);
    check("val_call_count", 32'(call_count), 32'd1);

    call(32'd20, 1'b1);
    check("void1_acc", acc, 32'd33);
    check("void1_discard", 32'(discard_count), 32'd1);
    check("void1_out_data", bus.out_data, 32'd11);
    check("void1_in_ready", 32'(bus.in_ready), 32'd1);

    call(32'd30, 1'b1);
    check("void2_acc", acc, 32'd64);
    check("void2_discard", 32'(discard_count), 32'd2);
    check("void2_call_count", 32'(call_count), 32'd3);

    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_out_data", bus.out_data, 32'd0);

    // Backpressure: 5 and 6 fill the FIFO, 7 stalls
    call(32'd5, 1'b0);
    check("bp_acc1", acc, 32'd70);
    call(32'd6, 1'b0);
    check("bp_acc2", acc, 32'd77);
    check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd7;
    tick();
    check("bp_stall_acc", acc, 32'd77);
    check("bp_stall_calls", 32'(call_count), 32'd5);
    check("bp_stall_head", bus.out_data, 32'd6);

    exp_q = {32'd6, 32'd7, 32'd8};
    bus.out_ready = 1'b1;
    cyc = 0;
    pop_cyc = -1;
    acc_cyc = -1;
    while (exp_q.size() != 0 && cyc < 10) begin
      accept_now = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        check("bp_order", bus.out_data, exp_q.pop_front());
        if (pop_cyc < 0) pop_cyc = cyc;
      end
      tick();
      if (accept_now) begin
        bus.in_valid = 1'b0;
        acc_cyc = cyc;
      end
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("bp_first_pop_cycle", 32'(pop_cyc), 32'd0);
    check("bp_accept_after_pop", 32'(acc_cyc), 32'd1);
    check("bp_acc_final", acc, 32'd85);
    check("bp_calls_final", 32'(call_count), 32'd6);
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Wrap
    do_reset();
    call(32'hFFFF_FFFF, 1'b0);
    check("wrap1_out_valid", 32'(bus.out_valid), 32'd1);
    check("wrap1_out_data", bus.out_data, 32'd0);
    check("wrap1_acc", acc, 32'd1);
    call(32'hFFFF_FFFE, 1'b0);
    check("wrap2_acc", acc, 32'd0);
    check("wrap2_head_held", bus.out_data, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("wrap2_out_data", bus.out_data, 32'hFFFF_FFFF);
    tick();
    bus.out_ready = 1'b0;
    check("wrap_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation with a concurrent call
    do_reset();
    call(32'd10, 1'b0);
    call(32'd20, 1'b1);
    call(32'd30, 1'b0);
    check("mid_acc", acc, 32'd64);
    check("mid_full", 32'(bus.in_ready), 32'd0);
    check("mid_head", bus.out_data, 32'd11);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd50;
    bus.in_void  = 1'b0;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", bus.out_data, 32'd0);
    check("mid_rst_acc", acc, 32'd1);
    check("mid_rst_calls", 32'(call_count), 32'd0);
    check("mid_rst_discards", 32'(discard_count), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("mid_rst_no_trace", 32'(bus.out_valid), 32'd0);
    check("mid_rst_acc_hold", acc, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
